// File: rtl/dm_sba_engine.sv
// dm_sba_engine: debug-module system-bus access engine; optional response timeout under DM_SBA_TIMEOUT_EN
module dm_sba_engine #(
    parameter int unsigned BusWidth      = 32,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  dmactive_i,
    input  logic [BusWidth-1:0]   sbaddress_i,
    input  logic                  sbaddress_write_valid_i,
    input  logic [BusWidth-1:0]   sbdata_i,
    input  logic                  sbdata_write_valid_i,
    input  logic                  sbdata_read_valid_i,
    input  logic                  sbreadonaddr_i,
    input  logic                  sbreadondata_i,
    input  logic                  sbautoincrement_i,
    input  logic [2:0]            sbaccess_i,
    output logic [BusWidth-1:0]   sbaddress_o,
    output logic [BusWidth-1:0]   sbdata_o,
    output logic                  sbdata_valid_o,
    output logic                  sbbusy_o,
    output logic                  sbbusyerror_o,
    output logic [2:0]            sberror_o,
    output logic                  sberror_valid_o,
    output logic                  master_req_o,
    output logic [BusWidth-1:0]   master_add_o,
    output logic                  master_we_o,
    output logic [BusWidth-1:0]   master_wdata_o,
    output logic [BusWidth/8-1:0] master_be_o,
    input  logic                  master_gnt_i,
    input  logic                  master_r_valid_i,
    input  logic                  master_r_err_i,
    input  logic [BusWidth-1:0]   master_r_rdata_i
);
    localparam int unsigned NB = BusWidth / 8;
    localparam int unsigned OW = $clog2(NB);

    typedef enum logic [2:0] {Idle, Read, Write, WaitRead, WaitWrite} state_e;

    state_e              state_q, state_d;
    logic [BusWidth-1:0] addr_q, addr_d, rdata_q, rdata_d, wdata_q, wdata_d;
    logic [2:0]          acc_q, acc_d, err_q, err_d;
    logic                inc_q, inc_d, dvalid_q, dvalid_d, busyerr_q, busyerr_d, errv_q, errv_d;
    logic [BusWidth-1:0] eff_addr, amask, wd_rep, rmask;
    logic                trig_w, trig_r, size_err, align_err;
    int                  be_full;

`ifdef DM_SBA_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TimeoutCycles + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = |TimeoutCycles;
`endif

    // New accesses check the address the debugger is writing this cycle, if any
    assign eff_addr  = sbaddress_write_valid_i ? sbaddress_i : addr_q;
    assign trig_w    = sbdata_write_valid_i;
    assign trig_r    = (sbaddress_write_valid_i & sbreadonaddr_i) | (sbdata_read_valid_i & sbreadondata_i);
    assign size_err  = sbaccess_i > 3'(OW);
    assign amask     = (BusWidth'(1) << sbaccess_i) - BusWidth'(1);
    assign align_err = |(eff_addr & amask);
    assign rmask     = (BusWidth'(1) << (8 << acc_q)) - BusWidth'(1);

    // Replicate the low access-sized chunk of sbdata across every byte lane
    always_comb begin
        wd_rep = '0;
        for (int i = 0; i < int'(NB); i++)
            wd_rep[8*i +: 8] = sbdata_i[8*(i & int'(amask[OW:0])) +: 8];
    end

    // Byte-enable pattern for the latched access size at the address byte offset
    assign be_full = ((1 << (1 << acc_q)) - 1) << addr_q[OW-1:0];

    // Next-state, datapath and pulse generation; dmactive low clears everything
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rdata_d   = rdata_q;
        wdata_d   = wdata_q;
        acc_d     = acc_q;
        inc_d     = inc_q;
        dvalid_d  = 1'b0;
        busyerr_d = 1'b0;
        errv_d    = 1'b0;
        err_d     = 3'd0;
`ifdef DM_SBA_TIMEOUT_EN
        cnt_d = (state_q == WaitRead || state_q == WaitWrite) ? cnt_q + 1'b1 : '0;
`endif
        case (state_q)
            Idle: begin
                if (sbaddress_write_valid_i) addr_d = sbaddress_i;
                if (trig_w || trig_r) begin
                    if (size_err) begin
                        errv_d = 1'b1;
                        err_d  = 3'd4;
                    end else if (align_err) begin
                        errv_d = 1'b1;
                        err_d  = 3'd3;
                    end else begin
                        state_d = trig_w ? Write : Read;
                        acc_d   = sbaccess_i;
                        inc_d   = sbautoincrement_i;
                        wdata_d = wd_rep;
                    end
                end
            end
            Read:  state_d = master_gnt_i ? WaitRead : Read;
            Write: state_d = master_gnt_i ? WaitWrite : Write;
            WaitRead, WaitWrite: begin
                if (master_r_valid_i) begin
                    state_d = Idle;
                    if (master_r_err_i) begin
                        errv_d = 1'b1;
                        err_d  = 3'd2;
                    end else begin
                        if (state_q == WaitRead) begin
                            rdata_d  = (master_r_rdata_i >> {addr_q[OW-1:0], 3'b000}) & rmask;
                            dvalid_d = 1'b1;
                        end
                        if (inc_q) addr_d = addr_q + (BusWidth'(1) << acc_q);
                    end
                end
`ifdef DM_SBA_TIMEOUT_EN
                else if (cnt_q == CW'(TimeoutCycles - 1)) begin
                    state_d = Idle;
                    errv_d  = 1'b1;
                    err_d   = 3'd1;
                end
`endif
            end
            default: state_d = Idle;
        endcase
        if (state_q != Idle && (trig_w || sbaddress_write_valid_i || (sbdata_read_valid_i && sbreadondata_i)))
            busyerr_d = 1'b1;
        if (!dmactive_i) begin
            state_d   = Idle;
            addr_d    = '0;
            rdata_d   = '0;
            wdata_d   = '0;
            acc_d     = 3'd0;
            inc_d     = 1'b0;
            dvalid_d  = 1'b0;
            busyerr_d = 1'b0;
            errv_d    = 1'b0;
            err_d     = 3'd0;
`ifdef DM_SBA_TIMEOUT_EN
            cnt_d = '0;
`endif
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= Idle;
            addr_q    <= '0;
            rdata_q   <= '0;
            wdata_q   <= '0;
            acc_q     <= 3'd0;
            inc_q     <= 1'b0;
            dvalid_q  <= 1'b0;
            busyerr_q <= 1'b0;
            errv_q    <= 1'b0;
            err_q     <= 3'd0;
`ifdef DM_SBA_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rdata_q   <= rdata_d;
            wdata_q   <= wdata_d;
            acc_q     <= acc_d;
            inc_q     <= inc_d;
            dvalid_q  <= dvalid_d;
            busyerr_q <= busyerr_d;
            errv_q    <= errv_d;
            err_q     <= err_d;
`ifdef DM_SBA_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign sbaddress_o     = addr_q;
    assign sbdata_o        = rdata_q;
    assign sbdata_valid_o  = dvalid_q;
    assign sbbusy_o        = state_q != Idle;
    assign sbbusyerror_o   = busyerr_q;
    assign sberror_o       = err_q;
    assign sberror_valid_o = errv_q;
    assign master_req_o    = state_q == Read || state_q == Write;
    assign master_add_o    = master_req_o ? addr_q : '0;
    assign master_we_o     = state_q == Write;
    assign master_wdata_o  = master_req_o ? wdata_q : '0;
    assign master_be_o     = master_req_o ? be_full[NB-1:0] : '0;

endmodule

// File: tb/tb_dm_sba_engine.sv
// tb_dm_sba_engine: directed vector bench for dm_sba_engine at BusWidth=32, TimeoutCycles=4
module tb_dm_sba_engine;
    logic        clk = 1'b0, rst_n = 1'b0, dmactive = 1'b1;
    logic [31:0] sbaddress = '0, sbdata = '0, r_rdata = '0;
    logic        addr_wv = 1'b0, data_wv = 1'b0, data_rv = 1'b0, rd_on_addr = 1'b0, rd_on_data = 1'b0;
    logic        autoinc = 1'b0, gnt = 1'b0, r_valid = 1'b0, r_err = 1'b0;
    logic [2:0]  access = '0;
    logic [31:0] sbaddress_o, sbdata_o, m_add, m_wdata;
    logic        sbdata_valid, busy, busyerr, errv, m_req, m_we;
    logic [2:0]  err;
    logic [3:0]  m_be;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    dm_sba_engine #(.BusWidth(32), .TimeoutCycles(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .dmactive_i(dmactive),
        .sbaddress_i(sbaddress), .sbaddress_write_valid_i(addr_wv),
        .sbdata_i(sbdata), .sbdata_write_valid_i(data_wv), .sbdata_read_valid_i(data_rv),
        .sbreadonaddr_i(rd_on_addr), .sbreadondata_i(rd_on_data),
        .sbautoincrement_i(autoinc), .sbaccess_i(access),
        .sbaddress_o(sbaddress_o), .sbdata_o(sbdata_o), .sbdata_valid_o(sbdata_valid),
        .sbbusy_o(busy), .sbbusyerror_o(busyerr), .sberror_o(err), .sberror_valid_o(errv),
        .master_req_o(m_req), .master_add_o(m_add), .master_we_o(m_we),
        .master_wdata_o(m_wdata), .master_be_o(m_be), .master_gnt_i(gnt),
        .master_r_valid_i(r_valid), .master_r_err_i(r_err), .master_r_rdata_i(r_rdata)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  acc;
        logic        inc;
        int          gdly;
        logic [31:0] rdata;
        logic        rerr;
        logic [2:0]  exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        string p;
        p = $sformatf("v%0d", n);
        sbaddress = v.addr; addr_wv = 1'b1; rd_on_addr = !v.wr;
        access = v.acc; autoinc = v.inc;
        tick();
        addr_wv = 1'b0; rd_on_addr = 1'b0;
        if (v.wr) begin
            sbdata = v.data; data_wv = 1'b1;
            tick();
            data_wv = 1'b0;
        end
        if (v.exp_err == 3'd3 || v.exp_err == 3'd4) begin
            chk({p, "_errv"}, errv, 1'b1);
            chk({p, "_errcode"}, err, v.exp_err);
            chk({p, "_noreq"}, m_req, 1'b0);
            tick();
            chk({p, "_errpulse"}, errv, 1'b0);
            chk({p, "_idle"}, busy, 1'b0);
        end else begin
            chk({p, "_req"}, m_req, 1'b1);
            chk({p, "_add"}, m_add, v.addr);
            chk({p, "_be"}, m_be, v.exp_be);
            chk({p, "_we"}, m_we, v.wr);
            if (v.wr) chk({p, "_wdata"}, m_wdata, v.exp_wdata);
            for (int k = 0; k < v.gdly; k++) begin
                tick();
                chk({p, "_reqhold"}, m_req, 1'b1);
                chk({p, "_addhold"}, m_add, v.addr);
            end
            gnt = 1'b1;
            tick();
            gnt = 1'b0;
            chk({p, "_reqdrop"}, m_req, 1'b0);
            chk({p, "_busy"}, busy, 1'b1);
            r_valid = 1'b1; r_rdata = v.rdata; r_err = v.rerr;
            tick();
            r_valid = 1'b0; r_err = 1'b0;
            chk({p, "_dvalid"}, sbdata_valid, !v.wr && !v.rerr);
            chk({p, "_errv"}, errv, v.rerr);
            if (v.rerr) chk({p, "_errcode"}, err, 3'd2);
            if (!v.wr && !v.rerr) chk({p, "_rdata"}, sbdata_o, v.exp_rdata);
            chk({p, "_idle"}, busy, 1'b0);
            tick();
            chk({p, "_dpulse"}, sbdata_valid, 1'b0);
        end
        chk({p, "_addr"}, sbaddress_o, v.exp_addr);
    endtask

    // Start a read at addr and stop once the engine is in WaitRead
    task automatic start_read(input logic [31:0] addr);
        sbaddress = addr; addr_wv = 1'b1; rd_on_addr = 1'b1; access = 3'd2; autoinc = 1'b0;
        tick();
        addr_wv = 1'b0; rd_on_addr = 1'b0; gnt = 1'b1;
        tick();
        gnt = 1'b0;
    endtask

    initial begin
        //          wr  addr          data          acc  inc gd rdata         rerr err  be    wdata         rdata         addr after
        vecs[0] = '{0, 32'h1000,     32'h0,        3'd2, 0, 2, 32'hDEADBEEF, 0, 3'd0, 4'hF, 32'h0,        32'hDEADBEEF, 32'h1000};
        vecs[1] = '{1, 32'h1002,     32'hABCD,     3'd1, 1, 0, 32'h0,        0, 3'd0, 4'hC, 32'hABCDABCD, 32'h0,        32'h1004};
        vecs[2] = '{0, 32'h2003,     32'h0,        3'd0, 1, 1, 32'h11223344, 0, 3'd0, 4'h8, 32'h0,        32'h11,       32'h2004};
        vecs[3] = '{0, 32'h2002,     32'h0,        3'd1, 0, 0, 32'h11223344, 0, 3'd0, 4'hC, 32'h0,        32'h1122,     32'h2002};
        vecs[4] = '{1, 32'h3001,     32'h5A,       3'd0, 1, 3, 32'h0,        0, 3'd0, 4'h2, 32'h5A5A5A5A, 32'h0,        32'h3002};
        vecs[5] = '{1, 32'h1001,     32'h1234,     3'd2, 0, 0, 32'h0,        0, 3'd3, 4'h0, 32'h0,        32'h0,        32'h1001};
        vecs[6] = '{0, 32'h1000,     32'h0,        3'd3, 0, 0, 32'h0,        0, 3'd4, 4'h0, 32'h0,        32'h0,        32'h1000};
        vecs[7] = '{0, 32'h4000,     32'h0,        3'd2, 1, 1, 32'h99999999, 1, 3'd0, 4'hF, 32'h0,        32'h0,        32'h4000};
        vecs[8] = '{0, 32'hFFFFFFFC, 32'h0,        3'd2, 1, 0, 32'h12345678, 0, 3'd0, 4'hF, 32'h0,        32'h12345678, 32'h0};
        vecs[9] = '{1, 32'h10,       32'hCAFEF00D, 3'd2, 0, 1, 32'h0,        0, 3'd0, 4'hF, 32'hCAFEF00D, 32'h0,        32'h10};

        #12;
        chk("rst_addr", sbaddress_o, 32'h0);
        chk("rst_data", sbdata_o, 32'h0);
        chk("rst_outs", {sbdata_valid, busy, busyerr, errv, err, m_req, m_we, m_be}, '0);
        chk("rst_bus", {m_add, m_wdata}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        start_read(32'h5000);
        data_wv = 1'b1; sbdata = 32'h1111;
        tick();
        data_wv = 1'b0;
        chk("busy_err_pulse", busyerr, 1'b1);
        sbaddress = 32'h9999; addr_wv = 1'b1;
        tick();
        addr_wv = 1'b0;
        chk("busy_no_req", m_req, 1'b0);
        chk("busy_err_addr", busyerr, 1'b1);
        tick();
        chk("busy_err_clear", busyerr, 1'b0);
        chk("busy_addr_kept", sbaddress_o, 32'h5000);
        r_valid = 1'b1; r_rdata = 32'h55;
        tick();
        r_valid = 1'b0;
        chk("busy_rd_valid", sbdata_valid, 1'b1);
        chk("busy_rd_data", sbdata_o, 32'h55);
        tick();
        chk("busy_no_second_req", m_req | busy, 1'b0);

        r_valid = 1'b1; r_rdata = 32'h77;
        tick();
        r_valid = 1'b0;
        chk("idle_resp_valid", sbdata_valid, 1'b0);
        chk("idle_resp_data", sbdata_o, 32'h55);
        chk("idle_resp_busy", busy, 1'b0);

        start_read(32'h7000);
`ifdef DM_SBA_TIMEOUT_EN
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("to_waiting", {busy, errv}, 2'b10);
        end
        tick();
        chk("to_errv", errv, 1'b1);
        chk("to_code", err, 3'd1);
        chk("to_idle", busy, 1'b0);
        chk("to_addr", sbaddress_o, 32'h7000);
        r_valid = 1'b1; r_rdata = 32'hAA;
        tick();
        r_valid = 1'b0;
        chk("to_late_ignored", sbdata_valid, 1'b0);
`else
        for (int k = 0; k < 20; k++) tick();
        chk("noto_busy", busy, 1'b1);
        chk("noto_noerr", errv, 1'b0);
        r_valid = 1'b1; r_rdata = 32'hAA;
        tick();
        r_valid = 1'b0;
        chk("noto_valid", sbdata_valid, 1'b1);
        chk("noto_data", sbdata_o, 32'hAA);
`endif
        tick();

        sbaddress = 32'h6000; addr_wv = 1'b1; rd_on_addr = 1'b1; access = 3'd2;
        tick();
        addr_wv = 1'b0; rd_on_addr = 1'b0;
        chk("dma_req_before", m_req, 1'b1);
        dmactive = 1'b0;
        tick();
        chk("dma_req", m_req, 1'b0);
        chk("dma_addr", sbaddress_o, 32'h0);
        chk("dma_busy", busy, 1'b0);
        chk("dma_data", sbdata_o, 32'h0);
        dmactive = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
